// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush scheduler for the IF-ID-EXE-MEM pipeline front
// Optional stall-cycle counters are built when STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
  parameter int FLUSH_HOLD = 1,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ID_EX_DH_Stall,
  input  logic              ID_MEM1_DH_Stall,
  input  logic              ID_MEM2_DH_Stall,
  input  logic              IF_ICacheBusy,
  input  logic              MEM_DCacheBusy,
  input  logic              EXE_DivBusy,
  input  logic              EXE_BranchFlush,
  input  logic              MEM_ExceptFlush,
  input  logic              Perf_Clr,
  output logic              PC_Wr,
  output logic              IF_Wr,
  output logic              ID_Wr,
  output logic              EXE_Wr,
  output logic              MEM_Wr,
  output logic              IF_Flush,
  output logic              ID_Flush,
  output logic              EXE_Flush,
  output logic              MEM_Flush,
  output logic              ID_DisWr,
  output logic              IF_Discard,
  output logic [PERF_W-1:0] Perf_DHCnt,
  output logic [PERF_W-1:0] Perf_ICacheCnt,
  output logic [PERF_W-1:0] Perf_BackendCnt
);

  typedef enum logic {ST_RUN, ST_DISCARD} state_t;

  localparam logic [2:0] HOLD_INIT = 3'(FLUSH_HOLD - 1);

  state_t     state;
  logic [2:0] hold_cnt;

  logic dh_stall;
  logic backend_busy;
  logic branch_take;
  logic win_backend;
  logic win_dh;
  logic win_icache;

  assign dh_stall     = ID_EX_DH_Stall | ID_MEM1_DH_Stall | ID_MEM2_DH_Stall;
  assign backend_busy = MEM_DCacheBusy | EXE_DivBusy;
  // A branch held in EXE behind a busy backend is simply seen again later.
  assign branch_take  = EXE_BranchFlush & ~backend_busy & ~MEM_ExceptFlush;
  assign win_backend  = ~MEM_ExceptFlush & backend_busy;
  assign win_dh       = (state == ST_RUN) & ~MEM_ExceptFlush & ~backend_busy
                        & ~EXE_BranchFlush & dh_stall;
  assign win_icache   = (state == ST_RUN) & ~MEM_ExceptFlush & ~backend_busy
                        & ~EXE_BranchFlush & ~dh_stall & IF_ICacheBusy;

  always_comb begin
    PC_Wr      = 1'b1;
    IF_Wr      = 1'b1;
    ID_Wr      = 1'b1;
    EXE_Wr     = 1'b1;
    MEM_Wr     = 1'b1;
    IF_Flush   = 1'b0;
    ID_Flush   = 1'b0;
    EXE_Flush  = 1'b0;
    MEM_Flush  = 1'b0;
    ID_DisWr   = 1'b0;
    IF_Discard = 1'b0;
    if (!resetn) begin
      PC_Wr     = 1'b0;
      IF_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EXE_Wr    = 1'b0;
      MEM_Wr    = 1'b0;
      IF_Flush  = 1'b1;
      ID_Flush  = 1'b1;
      EXE_Flush = 1'b1;
      MEM_Flush = 1'b1;
    end else if (state == ST_RUN) begin
      if (MEM_ExceptFlush) begin
        IF_Flush  = 1'b1;
        ID_Flush  = 1'b1;
        EXE_Flush = 1'b1;
        MEM_Flush = 1'b1;
      end else if (backend_busy) begin
        PC_Wr  = 1'b0;
        IF_Wr  = 1'b0;
        ID_Wr  = 1'b0;
        EXE_Wr = 1'b0;
        MEM_Wr = 1'b0;
      end else if (EXE_BranchFlush) begin
        IF_Flush = 1'b1;
      end else if (dh_stall) begin
        PC_Wr    = 1'b0;
        IF_Wr    = 1'b0;
        ID_Wr    = 1'b0;
        ID_DisWr = 1'b1;
      end else if (IF_ICacheBusy) begin
        PC_Wr    = 1'b0;
        IF_Wr    = 1'b0;
        ID_Flush = 1'b1;
      end
    end else begin
      // Stale fetch still outstanding: IF stays empty until it returns.
      IF_Discard = 1'b1;
      PC_Wr      = 1'b0;
      IF_Wr      = 1'b0;
      IF_Flush   = 1'b1;
      ID_Flush   = 1'b1;
      if (MEM_ExceptFlush) begin
        PC_Wr     = 1'b1;
        EXE_Flush = 1'b1;
        MEM_Flush = 1'b1;
      end else if (backend_busy) begin
        ID_Wr    = 1'b0;
        EXE_Wr   = 1'b0;
        MEM_Wr   = 1'b0;
        IF_Flush = 1'b0;
        ID_Flush = 1'b0;
      end else if (EXE_BranchFlush) begin
        PC_Wr = 1'b1;
      end
    end
    if (resetn && hold_cnt != 3'd0) begin
      ID_Flush  = 1'b1;
      EXE_Flush = 1'b1;
      MEM_Flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_RUN;
      hold_cnt <= 3'd0;
    end else begin
      if (MEM_ExceptFlush)
        hold_cnt <= HOLD_INIT;
      else if (hold_cnt != 3'd0)
        hold_cnt <= hold_cnt - 3'd1;
      case (state)
        ST_RUN:
          if ((MEM_ExceptFlush | branch_take) & IF_ICacheBusy)
            state <= ST_DISCARD;
        ST_DISCARD:
          if (!IF_ICacheBusy)
            state <= ST_RUN;
        default:
          state <= ST_RUN;
      endcase
    end
  end

`ifdef STALL_PERF_EN
  localparam logic [PERF_W-1:0] CNT_ONE = PERF_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      Perf_DHCnt      <= '0;
      Perf_ICacheCnt  <= '0;
      Perf_BackendCnt <= '0;
    end else if (Perf_Clr) begin
      Perf_DHCnt      <= '0;
      Perf_ICacheCnt  <= '0;
      Perf_BackendCnt <= '0;
    end else begin
      if (win_dh && Perf_DHCnt != '1)
        Perf_DHCnt <= Perf_DHCnt + CNT_ONE;
      if (win_icache && Perf_ICacheCnt != '1)
        Perf_ICacheCnt <= Perf_ICacheCnt + CNT_ONE;
      if (win_backend && Perf_BackendCnt != '1)
        Perf_BackendCnt <= Perf_BackendCnt + CNT_ONE;
    end
  end
`else
  logic unused_perf;
  assign unused_perf     = &{1'b0, Perf_Clr, win_dh, win_icache, win_backend};
  assign Perf_DHCnt      = '0;
  assign Perf_ICacheCnt  = '0;
  assign Perf_BackendCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl
// Output vector: {PC,IF,ID,EXE,MEM _Wr, IF,ID,EXE,MEM _Flush, ID_DisWr, IF_Discard}.
module tb_pipe_stall_ctrl;

  localparam int PW = 3;

  localparam logic [7:0] I_DHE = 8'h80, I_DH1 = 8'h40, I_DH2 = 8'h20, I_IC = 8'h10;
  localparam logic [7:0] I_DC  = 8'h08, I_DIV = 8'h04, I_BR  = 8'h02, I_EXC = 8'h01;

  localparam logic [10:0] O_DEF   = 11'b11111_0000_0_0;
  localparam logic [10:0] O_RST   = 11'b00000_1111_0_0;
  localparam logic [10:0] O_DH    = 11'b00011_0000_1_0;
  localparam logic [10:0] O_BR    = 11'b11111_1000_0_0;
  localparam logic [10:0] O_ICB   = 11'b00111_0100_0_0;
  localparam logic [10:0] O_STALL = 11'b00000_0000_0_0;
  localparam logic [10:0] O_EXC   = 11'b11111_1111_0_0;
  localparam logic [10:0] O_HOLD  = 11'b11111_0111_0_0;
  localparam logic [10:0] O_DISC  = 11'b00111_1100_0_1;
  localparam logic [10:0] O_DEXC  = 11'b10111_1111_0_1;
  localparam logic [10:0] O_DHOLD = 11'b00111_1111_0_1;

  logic clk = 1'b0;
  logic resetn;
  logic dh_ex, dh_m1, dh_m2, ic_busy, dc_busy, div_busy, br_flush, exc_flush, perf_clr;
  logic pc_wr, if_wr, id_wr, exe_wr, mem_wr;
  logic if_flush, id_flush, exe_flush, mem_flush, id_diswr, if_discard;
  logic [PW-1:0] perf_dh, perf_ic, perf_be;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  pipe_stall_ctrl #(.FLUSH_HOLD(3), .PERF_W(PW)) dut (
    .clk(clk), .resetn(resetn),
    .ID_EX_DH_Stall(dh_ex), .ID_MEM1_DH_Stall(dh_m1), .ID_MEM2_DH_Stall(dh_m2),
    .IF_ICacheBusy(ic_busy), .MEM_DCacheBusy(dc_busy), .EXE_DivBusy(div_busy),
    .EXE_BranchFlush(br_flush), .MEM_ExceptFlush(exc_flush), .Perf_Clr(perf_clr),
    .PC_Wr(pc_wr), .IF_Wr(if_wr), .ID_Wr(id_wr), .EXE_Wr(exe_wr), .MEM_Wr(mem_wr),
    .IF_Flush(if_flush), .ID_Flush(id_flush), .EXE_Flush(exe_flush), .MEM_Flush(mem_flush),
    .ID_DisWr(id_diswr), .IF_Discard(if_discard),
    .Perf_DHCnt(perf_dh), .Perf_ICacheCnt(perf_ic), .Perf_BackendCnt(perf_be)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [7:0] in, input logic [10:0] exp);
    sb_entry_t e;
    @(posedge clk);
    #1;
    {dh_ex, dh_m1, dh_m2, ic_busy, dc_busy, div_busy, br_flush, exc_flush} = in;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      check(e.tag, {21'd0, pc_wr, if_wr, id_wr, exe_wr, mem_wr, if_flush, id_flush,
                    exe_flush, mem_flush, id_diswr, if_discard}, {21'd0, e.exp});
    end
  end

  task automatic check_perf(input string tag, input int dh, input int ic, input int be);
    @(negedge clk);
    #1;
    check({tag, "_dh"}, 32'(perf_dh), 32'(dh));
    check({tag, "_ic"}, 32'(perf_ic), 32'(ic));
    check({tag, "_be"}, 32'(perf_be), 32'(be));
  endtask

  initial begin
    sb_entry_t e;
    resetn = 1'b0;
    perf_clr = 1'b0;
    {dh_ex, dh_m1, dh_m2, ic_busy, dc_busy, div_busy, br_flush, exc_flush} = 8'h00;
    e.tag = "reset";
    e.exp = O_RST;
    sb.push_back(e);
    @(negedge clk);
    #1;
    check("reset_perf", 32'({perf_dh, perf_ic, perf_be}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    drive("idle", 8'h00, O_DEF);
    drive("dh_m1_0", I_DH1, O_DH);
    drive("dh_m1_1", I_DH1, O_DH);
    drive("after_dh", 8'h00, O_DEF);
    drive("dh_ex", I_DHE, O_DH);
    drive("dh_m2", I_DH2, O_DH);
    drive("icache", I_IC, O_ICB);
    drive("after_ic", 8'h00, O_DEF);

    drive("br_ic", I_BR | I_IC, O_BR);
    for (int i = 0; i < 3; i++) drive("disc_busy", I_IC, O_DISC);
    drive("disc_exit", 8'h00, O_DISC);
    drive("run_again", 8'h00, O_DEF);

    drive("exc", I_EXC, O_EXC);
    drive("hold_1", 8'h00, O_HOLD);
    drive("hold_2", 8'h00, O_HOLD);
    drive("hold_end", 8'h00, O_DEF);

    drive("div_br_0", I_DIV | I_BR, O_STALL);
    drive("div_br_1", I_DIV | I_BR, O_STALL);
    drive("br_late", I_BR, O_BR);
    drive("after_br", 8'h00, O_DEF);

    drive("exc_br", I_EXC | I_BR, O_EXC);
    drive("exc_br_h1", 8'h00, O_HOLD);
    drive("exc_br_h2", 8'h00, O_HOLD);
    drive("exc_br_end", 8'h00, O_DEF);

    drive("exc_dc", I_EXC | I_DC, O_EXC);
    drive("exc_dc_h1", 8'h00, O_HOLD);
    drive("exc_dc_h2", 8'h00, O_HOLD);
    drive("exc_dc_end", 8'h00, O_DEF);

    drive("br_ic2", I_BR | I_IC, O_BR);
    drive("disc2", I_IC, O_DISC);
    drive("disc_exc", I_EXC | I_IC, O_DEXC);
    drive("disc_h1", I_IC, O_DHOLD);
    drive("disc_h2", I_IC, O_DHOLD);
    drive("disc2_exit", 8'h00, O_DISC);
    drive("run_again2", 8'h00, O_DEF);

    drive("dh_over_ic", I_DHE | I_IC, O_DH);
    drive("idle_p", 8'h00, O_DEF);

`ifdef STALL_PERF_EN
    check_perf("perf", 5, 1, 2);
    perf_clr = 1'b1;
    drive("clr", 8'h00, O_DEF);
    perf_clr = 1'b0;
    check_perf("perf_clr", 0, 0, 0);
    for (int i = 0; i < 9; i++) drive("dh_sat", I_DH2, O_DH);
    drive("idle_sat", 8'h00, O_DEF);
    check_perf("perf_sat", 7, 0, 0);
`else
    check_perf("perf_off", 0, 0, 0);
`endif

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
